// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder that reuses one 4-bit
// carry-lookahead slice, one nibble per cycle, LSB nibble first.
// Handshake: start (accepted in IDLE) -> busy -> one-cycle done pulse.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' input for a - b.

// 4-bit carry-lookahead slice: sum plus group generate/propagate.
module carrylookahead4bit (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       C,
  output logic [3:0] S,
  output logic       g,
  output logic       p
);

  logic [3:0] w_gi;
  logic [3:0] w_pi;
  logic [3:0] w_c;

  // Bit generate/propagate, lookahead carries, group terms.
  always_comb begin
    w_gi   = A & B;
    w_pi   = A ^ B;
    w_c[0] = C;
    w_c[1] = w_gi[0] | (w_pi[0] & C);
    w_c[2] = w_gi[1] | (w_pi[1] & w_gi[0]) | (w_pi[1] & w_pi[0] & C);
    w_c[3] = w_gi[2] | (w_pi[2] & w_gi[1]) | (w_pi[2] & w_pi[1] & w_gi[0])
           | (w_pi[2] & w_pi[1] & w_pi[0] & C);
    S      = w_pi ^ w_c;
    g      = w_gi[3] | (w_pi[3] & w_gi[2]) | (w_pi[3] & w_pi[2] & w_gi[1])
           | (w_pi[3] & w_pi[2] & w_pi[1] & w_gi[0]);
    p      = &w_pi;
  end

endmodule

module nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned NIB = WIDTH / 4;
  localparam int unsigned IW  = $clog2(NIB);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic [IW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_cout;
  logic             r_ovf;
`ifdef SERIAL_ADD_SUB_EN
  logic             r_sub;
`endif

  logic [3:0] w_a_nib;
  logic [3:0] w_b_nib;
  logic [3:0] w_s;
  logic       w_g;
  logic       w_p;
  logic       w_carry_next;
  logic       w_msb_cin;
  logic       w_last;

  // Select the current nibble; subtraction inverts B on the fly so the
  // stored operand stays exactly as captured.
  always_comb begin
    w_a_nib = r_a[{r_idx, 2'b00} +: 4];
`ifdef SERIAL_ADD_SUB_EN
    w_b_nib = r_b[{r_idx, 2'b00} +: 4] ^ {4{r_sub}};
`else
    w_b_nib = r_b[{r_idx, 2'b00} +: 4];
`endif
    w_carry_next = w_g | (w_p & r_carry);
    // Carry into the MSB recovered from the MSB sum bit of the last nibble.
    w_msb_cin    = w_a_nib[3] ^ w_b_nib[3] ^ w_s[3];
    w_last       = (r_idx == IW'(NIB - 1));
  end

  carrylookahead4bit u_slice (
    .A (w_a_nib),
    .B (w_b_nib),
    .C (r_carry),
    .S (w_s),
    .g (w_g),
    .p (w_p)
  );

  // Control FSM and datapath registers; all outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      r_sub   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_sum   <= '0;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
`ifdef SERIAL_ADD_SUB_EN
            r_sub   <= sub;
            r_carry <= sub ? 1'b1 : cin;
`else
            r_carry <= cin;
`endif
          end
        end
        ST_RUN: begin
          r_sum[{r_idx, 2'b00} +: 4] <= w_s;
          r_carry <= w_carry_next;
          if (w_last) begin
            r_cout  <= w_carry_next;
            r_ovf   <= w_carry_next ^ w_msb_cin;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Testbench for nibble_serial_adder (WIDTH=16): directed vectors, dropped
// requests, reset abort, random and back-to-back operations against an
// arithmetic reference model. Define SERIAL_ADD_SUB_EN to exercise subtract.
module tb_nibble_serial_adder;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef SERIAL_ADD_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         overflow;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .cin      (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub      (sub),
`endif
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Reference: plain integer add / subtract; returns {overflow, cout, sum}.
  function automatic logic [W+1:0] ref_op(logic [W-1:0] x, logic [W-1:0] y,
                                          logic c, logic s);
    logic [W:0]   full;
    logic [W-1:0] yy;
    logic         ci;
    logic         ov;
    yy   = s ? ~y : y;
    ci   = s ? 1'b1 : c;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, ci};
    ov   = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {ov, full};
  endfunction

  // Present a request for one edge, then scramble the operand inputs.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc);
    a = ta; b = tb2; cin = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'($urandom);
`endif
  endtask

  // Edges until done is seen (bounded); -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; a = '1; b = '1; cin = 1'b1;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    repeat (3) step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL reset_sum: got %h expected 0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL reset_cout: got %b expected 0", cout); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed;
    logic [W-1:0] va [3] = '{16'hFFFF, 16'h7FFF, 16'h1234};
    logic [W-1:0] vb [3] = '{16'h0001, 16'h0001, 16'h4321};
    logic         vc [3] = '{1'b0, 1'b0, 1'b1};
    logic [W-1:0] es [3] = '{16'h0000, 16'h8000, 16'h5556};
    logic         ec [3] = '{1'b1, 1'b0, 1'b0};
    logic         eo [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vb[i], vc[i]);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy_run: got %b expected 1", i, busy); end
      n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL dir%0d_sum_cleared: got %h expected 0000", i, sum); end
      wait_done(lat);
      n_cmp++; if (lat !== NIB) begin n_err++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, NIB); end
      n_cmp++; if (sum !== es[i]) begin n_err++; $display("FAIL dir%0d_sum: got %h expected %h", i, sum, es[i]); end
      n_cmp++; if (cout !== ec[i]) begin n_err++; $display("FAIL dir%0d_cout: got %b expected %b", i, cout, ec[i]); end
      n_cmp++; if (overflow !== eo[i]) begin n_err++; $display("FAIL dir%0d_ovf: got %b expected %b", i, overflow, eo[i]); end
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL dir%0d_busy_done: got %b expected 1", i, busy); end
      step();
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL dir%0d_idle: got busy,done=%b expected 00", i, {busy, done}); end
      repeat (2) step();
      n_cmp++; if ({overflow, cout, sum} !== {eo[i], ec[i], es[i]}) begin
        n_err++; $display("FAIL dir%0d_hold: got %h expected %h", i, {overflow, cout, sum}, {eo[i], ec[i], es[i]});
      end
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    int extra;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    issue(16'h0F0F, 16'h0101, 1'b0);
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    repeat (2) step();
    start = 1'b0;
    wait_done(lat);
    n_cmp++; if (lat !== NIB - 2) begin n_err++; $display("FAIL ign_latency: got %0d expected %0d", lat, NIB - 2); end
    n_cmp++; if (sum !== 16'h1010) begin n_err++; $display("FAIL ign_sum: got %h expected 1010", sum); end
    step();
    extra = 0;
    repeat (8) begin
      step();
      if (busy || done) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_err++; $display("FAIL ign_no_second_op: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_abort;
    int lat;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    issue(16'hFFFF, 16'hFFFF, 1'b0);
    wait_done(lat);
    step();
    issue(16'h7FFF, 16'h7FFF, 1'b0);
    step();
    rst = 1'b1;
    step();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b expected 0", done); end
    n_cmp++; if (sum !== '0) begin n_err++; $display("FAIL abort_sum: got %h expected 0000", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL abort_cout: got %b expected 0", cout); end
    rst = 1'b0;
    step();
    issue(16'h0001, 16'h0001, 1'b0);
    wait_done(lat);
    n_cmp++; if (lat !== NIB) begin n_err++; $display("FAIL abort_next_latency: got %0d expected %0d", lat, NIB); end
    n_cmp++; if (sum !== 16'h0002) begin n_err++; $display("FAIL abort_next_sum: got %h expected 0002", sum); end
    step();
  endtask

  task automatic test_random;
    logic [W-1:0] ta, tb2;
    logic tc, ts;
    logic [W+1:0] exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ta = W'($urandom); tb2 = W'($urandom); tc = 1'($urandom);
      if (i % 8 == 0) ta = '1;
      if (i % 8 == 1) begin ta = 16'h8000; tb2 = 16'h8000; end
      ts = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ts = 1'($urandom);
      sub = ts;
`endif
      exp = ref_op(ta, tb2, tc, ts);
      issue(ta, tb2, tc);
      wait_done(lat);
      n_cmp++; if (lat !== NIB) begin n_err++; $display("FAIL rnd%0d_latency: got %0d expected %0d", i, lat, NIB); end
      n_cmp++; if ({overflow, cout, sum} !== exp) begin
        n_err++; $display("FAIL rnd%0d_result: a=%h b=%h cin=%b sub=%b got ovf,cout,sum=%h expected %h", i, ta, tb2, tc, ts, {overflow, cout, sum}, exp);
      end
      step();
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] ta, tb2;
    logic tc, ts;
    logic [W+1:0] exp;
    int lat;
`ifdef SERIAL_ADD_SUB_EN
    sub = 1'b0;
`endif
    issue(16'h0001, 16'h0002, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      // Now in DONE: request the next op immediately; first edge must ignore it.
      ta = W'($urandom); tb2 = W'($urandom); tc = 1'($urandom); ts = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
      ts = 1'($urandom);
      sub = ts;
`endif
      exp = ref_op(ta, tb2, tc, ts);
      a = ta; b = tb2; cin = tc; start = 1'b1;
      step();
      n_cmp++; if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL b2b%0d_idle_gap: got busy,done=%b expected 00", i, {busy, done}); end
      issue(ta, tb2, tc);
      n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b%0d_accept: got %b expected 1", i, busy); end
      wait_done(lat);
      n_cmp++; if (lat !== NIB) begin n_err++; $display("FAIL b2b%0d_latency: got %0d expected %0d", i, lat, NIB); end
      n_cmp++; if ({overflow, cout, sum} !== exp) begin
        n_err++; $display("FAIL b2b%0d_result: got %h expected %h", i, {overflow, cout, sum}, exp);
      end
    end
    step();
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    int lat;
    sub = 1'b1;
    issue(16'h0005, 16'h0007, 1'b0);
    wait_done(lat);
    n_cmp++; if (sum !== 16'hFFFE) begin n_err++; $display("FAIL sub1_sum: got %h expected fffe", sum); end
    n_cmp++; if (cout !== 1'b0) begin n_err++; $display("FAIL sub1_cout: got %b expected 0", cout); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL sub1_ovf: got %b expected 0", overflow); end
    step();
    sub = 1'b1;
    issue(16'h8000, 16'h0001, 1'b0);
    wait_done(lat);
    n_cmp++; if (sum !== 16'h7FFF) begin n_err++; $display("FAIL sub2_sum: got %h expected 7fff", sum); end
    n_cmp++; if (cout !== 1'b1) begin n_err++; $display("FAIL sub2_cout: got %b expected 1", cout); end
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL sub2_ovf: got %b expected 1", overflow); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_reset_abort();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
